// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with hold-until-release grants and a bounded hold time.
// A holder is revoked after MAX_HOLD grant cycles only if another requester is waiting.
module rr_arbiter4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     r_state;
    logic [1:0] r_ptr;
    logic [7:0] r_hcnt;
    logic [3:0] r_gnt;
    logic [1:0] r_idx;
    logic       r_valid;

    logic [3:0] w_rot;
    logic [1:0] w_off;
    logic [1:0] w_sel;
    logic       w_any;
    logic [3:0] w_holder_mask;
    logic       w_others;
    logic       w_hold;
    logic       w_timeout;

    // Requests rotated so that bit 0 is the current highest-priority requester.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rot
            assign w_rot[gi] = req[2'(r_ptr + 2'(gi))];
        end
    endgenerate

    always_comb begin
        w_off = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = 2'(k);
            end
        end
    end

    assign w_sel         = r_ptr + w_off;
    assign w_any         = |req;
    assign w_holder_mask = 4'b0001 << r_idx;
    assign w_others      = |(req & ~w_holder_mask);
    assign w_hold        = req[r_idx];
    assign w_timeout     = (r_hcnt == HOLD_LAST) && w_others;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= 2'd0;
            r_hcnt  <= 8'd0;
            r_gnt   <= 4'b0000;
            r_idx   <= 2'd0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state <= ST_GRANT;
                        r_idx   <= w_sel;
                        r_gnt   <= 4'b0001 << w_sel;
                        r_valid <= 1'b1;
                        r_ptr   <= w_sel + 2'd1;
                        r_hcnt  <= 8'd0;
                    end
                end
                ST_GRANT: begin
                    // Release and timeout both end in the same dead cycle.
                    if (!w_hold || w_timeout) begin
                        r_state <= ST_IDLE;
                        r_gnt   <= 4'b0000;
                        r_valid <= 1'b0;
                    end else if (r_hcnt != HOLD_LAST) begin
                        r_hcnt <= r_hcnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= 4'b0000;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_idx;
    assign gnt_valid = r_valid;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Randomised and directed bench for rr_arbiter4: a driver pushes expected outputs from a
// cycle-counting reference model into a queue, a negedge monitor pops and compares them.
module tb_rr_arbiter4;

    localparam int MAX_HOLD = 8;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;

    rr_arbiter4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx),
        .gnt_valid(gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       valid;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cycle  = 0;

    // Reference model: owner (-1 = none), next-priority index, cycles held so far.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;
    int m_last  = 0;

    task automatic model_step(input logic r, input logic [3:0] q);
        bit others;
        if (r) begin
            m_owner = -1;
            m_ptr   = 0;
            m_held  = 0;
            m_last  = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < 4; k++) begin
                if (m_owner < 0 && q[(m_ptr + k) % 4]) begin
                    m_owner = (m_ptr + k) % 4;
                end
            end
            if (m_owner >= 0) begin
                m_ptr  = (m_owner + 1) % 4;
                m_held = 1;
                m_last = m_owner;
            end
        end else begin
            others = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (k != m_owner && q[k]) others = 1'b1;
            end
            if (!q[m_owner]) m_owner = -1;
            else if (m_held >= MAX_HOLD && others) m_owner = -1;
            else m_held++;
        end
    endtask

    task automatic step(input logic r, input logic [3:0] q);
        exp_t e;
        rst = r;
        req = q;
        @(posedge clk);
        model_step(r, q);
        cycle++;
        e.valid = (m_owner >= 0);
        e.idx   = 2'(m_last);
        e.gnt   = e.valid ? (4'b0001 << m_last) : 4'b0000;
        e.cyc   = cycle;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic chk(input string name, input int cyc, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%b expected=%b", name, cyc, act, exp);
        end
    endtask

    // Monitor: one line per compared cycle, plus the structural invariants.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("gnt", e.cyc, gnt, e.gnt);
                chk("gnt_idx", e.cyc, {2'b00, gnt_idx}, {2'b00, e.idx});
                chk("gnt_valid", e.cyc, {3'b000, gnt_valid}, {3'b000, e.valid});
                chk("onehot0", e.cyc, {3'b000, $onehot0(gnt)}, 4'b0001);
                if (gnt_valid === 1'b0) chk("idle_zero", e.cyc, gnt, 4'b0000);
                else chk("decode", e.cyc, gnt, 4'b0001 << gnt_idx);
                $display("cycle=%0d rst=%b req=%b gnt=%b idx=%0d valid=%b", e.cyc, rst, req, gnt, gnt_idx, gnt_valid);
            end
        end
    end

    initial begin
        int bound;
        logic [3:0] rq;
        rst = 1'b1;
        req = 4'b0000;
        #1;
        repeat (3) step(1'b1, 4'b1111);

        // All request: first grant to 0, then full rotation with hold limit.
        repeat (40) step(1'b0, 4'b1111);
        repeat (3) step(1'b0, 4'b0000);

        // Lone requester is never revoked.
        repeat (20) step(1'b0, 4'b0100);
        repeat (2) step(1'b0, 4'b0000);

        // Get requester 1 the grant, release after 3 cycles while 3 waits.
        step(1'b0, 4'b0010);
        repeat (2) step(1'b0, 4'b1010);
        repeat (3) step(1'b0, 4'b1000);
        repeat (2) step(1'b0, 4'b0000);

        // Reset mid-grant while requester 2 holds.
        bound = 0;
        while (!(m_owner == 2) && bound < 60) begin
            step(1'b0, 4'b1111);
            bound++;
        end
        checks++;
        if (m_owner != 2) begin
            errors++;
            $display("FAIL reach_owner2 got=%0d expected=2", m_owner);
        end
        step(1'b1, 4'b1111);
        repeat (3) step(1'b0, 4'b1111);

        // Random traffic with sticky requests and rare resets.
        rq = 4'b0000;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
            step($urandom_range(0, 199) == 0, rq);
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
